vram_arbiter: RTL and testbench

Single-port framebuffer controller for the Chip-8 machine. It shares one 256-byte display RAM (64×32 pixels, 1 bpp) between two users:
- video scanout reads, which always win the port;
- the sprite blitter, served as XOR read-modify-write sequences with collision detection, plus a full-screen clear.

It sits between the chip8 core's blitter/scanout logic and the display RAM, in the `clk_25M` domain.

---
 rtl/vram_arbiter_if.sv | 33 +++
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bundle of the scanout, blitter and display-RAM signals around vram_arbiter.
// The arbiter is the slave; scanout/blitter logic and the RAM form the master side.
interface vram_arbiter_if;
   logic       vid_req;
   logic [7:0] vid_addr;
   logic       vid_valid;
   logic [7:0] vid_data;
   logic       blt_req;
   logic [5:0] blt_x;
   logic [4:0] blt_y;
   logic [7:0] blt_data;
   logic       clr_req;
   logic       busy;
   logic       blt_done;
   logic       clr_done;
   logic       collision;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;

   modport slave (
      input  vid_req, vid_addr, blt_req, blt_x, blt_y, blt_data, clr_req, mem_rdata,
      output vid_valid, vid_data, busy, blt_done, clr_done, collision,
             mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vid_req, vid_addr, blt_req, blt_x, blt_y, blt_data, clr_req, mem_rdata,
      input  vid_valid, vid_data, busy, blt_done, clr_done, collision,
             mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Chip-8 framebuffer port arbiter: scanout reads always win, the blitter runs
// XOR read-modify-write sprite rows with collision detect and a full clear.
module vram_arbiter (
   input  logic          clk,
   input  logic          reset_n,
   vram_arbiter_if.slave bus
);
   typedef enum logic [3:0] {IDLE, RD0, CAP0, WR0, RD1, CAP1, WR1, CLR, DONE} state_t;

   state_t     state, next_state;
   logic [5:0] x_q;
   logic [4:0] y_q;
   logic [7:0] data_q;
   logic [7:0] old_q;
   logic [7:0] clr_cnt;
   logic       op_clr;
   logic       collision_q;
   logic       vid_valid_q;
   logic       blt_done_q;
   logic       clr_done_q;
   logic       port_free;
   logic       accept_clr;
   logic       accept_blt;
   logic [2:0] col1;
   logic [7:0] addr0;
   logic [7:0] addr1;
   logic [15:0] masks;

   // Upper byte is the mask for column c, lower byte spills into column c+1.
   function automatic logic [15:0] spread_mask(input logic [7:0] d, input logic [2:0] s);
      return {d, 8'h00} >> s;
   endfunction

   assign port_free  = !bus.vid_req;
   assign accept_clr = (state == IDLE) && bus.clr_req;
   assign accept_blt = (state == IDLE) && !bus.clr_req && bus.blt_req;
   assign col1       = x_q[5:3] + 3'd1;
   assign addr0      = {y_q, x_q[5:3]};
   assign addr1      = {y_q, col1};
   assign masks      = spread_mask(data_q, x_q[2:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (bus.clr_req)      next_state = CLR;
            else if (bus.blt_req) next_state = RD0;
         end
         RD0:  if (port_free) next_state = CAP0;
         CAP0: next_state = WR0;
         WR0:  if (port_free) next_state = (x_q[2:0] != 3'd0) ? RD1 : DONE;
         RD1:  if (port_free) next_state = CAP1;
         CAP1: next_state = WR1;
         WR1:  if (port_free) next_state = DONE;
         CLR:  if (port_free && clr_cnt == 8'hFF) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_addr  = 8'h00;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = 8'h00;
      if (bus.vid_req) begin
         bus.mem_addr = bus.vid_addr;
      end else begin
         case (state)
            RD0: bus.mem_addr = addr0;
            WR0: begin
               bus.mem_addr  = addr0;
               bus.mem_we    = 1'b1;
               bus.mem_wdata = old_q ^ masks[15:8];
            end
            RD1: bus.mem_addr = addr1;
            WR1: begin
               bus.mem_addr  = addr1;
               bus.mem_we    = 1'b1;
               bus.mem_wdata = old_q ^ masks[7:0];
            end
            CLR: begin
               bus.mem_addr = clr_cnt;
               bus.mem_we   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_cnt     <= 8'h00;
         op_clr      <= 1'b0;
         collision_q <= 1'b0;
         vid_valid_q <= 1'b0;
         blt_done_q  <= 1'b0;
         clr_done_q  <= 1'b0;
      end else begin
         // The owner tag: a granted video read returns its byte next cycle.
         vid_valid_q <= bus.vid_req;
         blt_done_q  <= (next_state == DONE) && !op_clr;
         clr_done_q  <= (next_state == DONE) && op_clr;
         if (accept_clr)      op_clr <= 1'b1;
         else if (accept_blt) op_clr <= 1'b0;
         if (accept_clr)                    clr_cnt <= 8'h00;
         else if (state == CLR && port_free) clr_cnt <= clr_cnt + 8'd1;
         if (accept_blt)
            collision_q <= 1'b0;
         else if (state == WR0 && port_free)
            collision_q <= collision_q | (|(old_q & masks[15:8]));
         else if (state == WR1 && port_free)
            collision_q <= collision_q | (|(old_q & masks[7:0]));
      end
   end

   always_ff @(posedge clk) begin
      if (accept_blt) begin
         x_q    <= bus.blt_x;
         y_q    <= bus.blt_y;
         data_q <= bus.blt_data;
      end
      if (state == CAP0 || state == CAP1) old_q <= bus.mem_rdata;
   end

   assign bus.vid_valid = vid_valid_q;
   assign bus.vid_data  = vid_valid_q ? bus.mem_rdata : 8'h00;
   assign bus.busy      = (state != IDLE);
   assign bus.blt_done  = blt_done_q;
   assign bus.clr_done  = clr_done_q;
   assign bus.collision = collision_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model plus a pixel-level reference
// framebuffer, directed cases followed by randomized blits with video contention.
module tb_vram_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   vram_arbiter_if bif();
   vram_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bif));

   logic [7:0] ram [256];
   logic [7:0] rdata_q;
   logic       bp_we = 1'b0;
   logic [7:0] bp_addr = 8'h00;
   logic [7:0] bp_data = 8'h00;

   always @(posedge clk) begin
      if (bp_we)           ram[bp_addr] <= bp_data;
      else if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
      rdata_q <= ram[bif.mem_addr];
   end
   assign bif.mem_rdata = rdata_q;

   bit         pix [32][64];
   bit         vpat [512];
   logic [7:0] vaddr [512];
   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref_byte(input int a);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = pix[a/8][(a%8)*8 + i];
      return r;
   endfunction

   task automatic ref_blit(input int x, input int y, input logic [7:0] d, output bit coll);
      coll = 0;
      for (int i = 0; i < 8; i++) begin
         if (d[7-i]) begin
            int px;
            px = (x + i) % 64;
            if (pix[y][px]) coll = 1;
            pix[y][px] = !pix[y][px];
         end
      end
   endtask

   task automatic poke(input int a, input logic [7:0] v);
      bp_we = 1'b1;
      bp_addr = a[7:0];
      bp_data = v;
      tick();
      bp_we = 1'b0;
      for (int i = 0; i < 8; i++) pix[a/8][(a%8)*8 + i] = v[7-i];
   endtask

   task automatic mem_cmp(input string tag);
      int n;
      n = 0;
      for (int a = 0; a < 256; a++) if (ram[a] !== ref_byte(a)) n++;
      check_eq(tag, n, 0);
   endtask

   function automatic logic [7:0] pick_vaddr(input int y);
      int vy;
      vy = (y + 1 + int'($urandom % 31)) % 32;
      return {vy[4:0], 3'($urandom % 8)};
   endfunction

   // Issues one operation in the current cycle (cycle A) and follows it to the done pulse.
   task automatic run_op(input string tag, input bit do_clr, input bit do_blt,
                         input int x, input int y, input logic [7:0] d);
      bit steps [$];
      int t, k, seen_k, exp_done;
      bit exp_coll, other, exp_vv, done_ok, done_bad;
      logic [7:0] exp_vd;
      vpat[0] = 0;
      if (do_clr) begin
         for (int i = 0; i < 256; i++) steps.push_back(1'b1);
      end else begin
         steps.push_back(1'b1); steps.push_back(1'b0); steps.push_back(1'b1);
         if (x % 8 != 0) begin
            steps.push_back(1'b1); steps.push_back(1'b0); steps.push_back(1'b1);
         end
      end
      t = 1;
      foreach (steps[i]) begin
         if (steps[i]) while (t < 512 && vpat[t]) t++;
         t++;
      end
      exp_done = t;
      exp_coll = 0;
      if (do_clr) begin
         for (int yy = 0; yy < 32; yy++) for (int xx = 0; xx < 64; xx++) pix[yy][xx] = 0;
      end else begin
         ref_blit(x, y, d, exp_coll);
      end
      bif.clr_req  = do_clr;
      bif.blt_req  = do_blt;
      bif.blt_x    = 6'(x);
      bif.blt_y    = 5'(y);
      bif.blt_data = d;
      exp_vv = 0; exp_vd = 8'h00;
      seen_k = -1; other = 0; k = 0;
      while (seen_k < 0 && k < exp_done + 20) begin
         tick();
         k++;
         if (k == 1) begin
            bif.clr_req = 1'b0;
            bif.blt_req = 1'b0;
            check_eq({tag, "_busy"}, bif.busy, 1);
         end
         check_eq({tag, "_vvalid"}, bif.vid_valid, exp_vv);
         if (exp_vv) check_eq({tag, "_vdata"}, bif.vid_data, exp_vd);
         done_ok  = do_clr ? bif.clr_done : bif.blt_done;
         done_bad = do_clr ? bif.blt_done : bif.clr_done;
         if (done_bad) other = 1;
         if (done_ok) begin
            seen_k = k;
            bif.vid_req = 1'b0;
         end else begin
            bif.vid_req  = (k < 512) ? vpat[k] : 1'b0;
            bif.vid_addr = (k < 512) ? vaddr[k] : 8'h00;
         end
         exp_vv = bif.vid_req;
         exp_vd = ref_byte(int'(bif.vid_addr));
      end
      check_eq({tag, "_latency"}, seen_k, exp_done);
      check_eq({tag, "_wrong_done"}, other, 0);
      if (!do_clr) check_eq({tag, "_collision"}, bif.collision, exp_coll);
      tick();
      check_eq({tag, "_vvalid_end"}, bif.vid_valid, exp_vv);
      check_eq({tag, "_idle"}, bif.busy, 0);
      check_eq({tag, "_pulse_end"}, {bif.blt_done, bif.clr_done}, 0);
      for (int i = 0; i < 512; i++) vpat[i] = 0;
   endtask

   initial begin
      bit seen_done;
      bif.vid_req = 0; bif.vid_addr = 0; bif.blt_req = 0; bif.blt_x = 0;
      bif.blt_y = 0; bif.blt_data = 0; bif.clr_req = 0;
      for (int i = 0; i < 512; i++) begin vpat[i] = 0; vaddr[i] = 8'h00; end
      repeat (3) tick();
      check_eq("rst_busy", bif.busy, 0);
      check_eq("rst_vid", {bif.vid_valid, bif.vid_data}, 0);
      check_eq("rst_done", {bif.blt_done, bif.clr_done}, 0);
      check_eq("rst_coll", bif.collision, 0);
      check_eq("rst_mem", {bif.mem_addr, bif.mem_we, bif.mem_wdata}, 0);
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 256; a++) poke(a, 8'h00);

      // Aligned blit
      poke(8'h13, 8'h0F);
      run_op("aligned", 0, 1, 24, 2, 8'hF0);
      check_eq("aligned_byte", ram[8'h13], 8'hFF);

      // Split blit wrapping within the row
      poke(8'h07, 8'h01);
      poke(8'h00, 8'h80);
      run_op("split", 0, 1, 62, 0, 8'hFF);
      check_eq("split_b0", ram[8'h07], 8'h02);
      check_eq("split_b1", ram[8'h00], 8'h7C);

      // Video contention for three cycles starting at RD0
      poke(8'h29, 8'h5A);
      poke(8'h60, 8'hC3);
      for (int i = 1; i <= 3; i++) begin vpat[i] = 1; vaddr[i] = 8'h5E + 8'(i); end
      vaddr[2] = 8'h60;
      run_op("contend", 0, 1, 8, 5, 8'h3C);
      check_eq("contend_byte", ram[8'h29], 8'h66);
      mem_cmp("mem_directed");

      // Clear takes priority over a simultaneous blit
      for (int a = 0; a < 256; a++) poke(a, 8'hAA);
      run_op("clear", 1, 1, 0, 0, 8'hFF);
      mem_cmp("clear_mem");

      // Reset during CAP1 of a split blit
      poke(15, 8'h01);
      bif.blt_req = 1; bif.blt_x = 6'd62; bif.blt_y = 5'd1; bif.blt_data = 8'hFF;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) bif.blt_req = 0;
      end
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", bif.busy, 0);
      check_eq("mid_rst_coll", bif.collision, 0);
      check_eq("mid_rst_mem", {bif.mem_addr, bif.mem_we, bif.mem_wdata}, 0);
      check_eq("mid_rst_out", {bif.vid_valid, bif.blt_done, bif.clr_done}, 0);
      tick();
      tick();
      reset_n = 1'b1;
      seen_done = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bif.blt_done || bif.clr_done) seen_done = 1;
      end
      check_eq("mid_rst_nodone", seen_done, 0);
      check_eq("mid_rst_idle", bif.busy, 0);
      check_eq("mid_rst_b0", ram[15], 8'h02);
      check_eq("mid_rst_b1", ram[8], 8'h00);
      poke(15, 8'h02);

      // Randomized blits over random contents with random scanout traffic
      for (int a = 0; a < 256; a++) poke(a, 8'($urandom));
      for (int n = 0; n < 25; n++) begin
         int rx, ry;
         rx = int'($urandom % 64);
         ry = int'($urandom % 32);
         for (int k = 1; k < 15; k++) begin
            vpat[k]  = ($urandom % 3 == 0);
            vaddr[k] = pick_vaddr(ry);
         end
         run_op("rand", 0, 1, rx, ry, 8'($urandom));
      end
      mem_cmp("rand_mem");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
